// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one SP float adder among NUM_REQ lanes.
// Ports: clk/reset; req_stb/req_a/req_b/req_ack per lane;
// rsp_z/rsp_stb/rsp_ack return path; add_a/add_b/add_z adder link; busy.
module fp_adder_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_stb,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [31:0]           rsp_z,
  output logic [NUM_REQ-1:0]    rsp_stb,
  input  logic [NUM_REQ-1:0]    rsp_ack,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_z,
  output logic                  busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [IW-1:0] g;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic [CW-1:0] cnt;

  // Round-robin search starting just after the last served lane.
  always_comb begin : p_pick
    int idx;
    logic [IW-1:0] sel;
    logic found;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      sel = IW'(idx);
      if (!found && req_stb[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (|req_stb) state_nx = WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (rsp_ack[g]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ack <= '0;
      rsp_stb <= '0;
      rsp_z   <= '0;
      add_a   <= '0;
      add_b   <= '0;
      g       <= '0;
      last    <= IW'(NUM_REQ - 1);
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_stb) begin
            g       <= pick;
            add_a   <= req_a[32*int'(pick) +: 32];
            add_b   <= req_b[32*int'(pick) +: 32];
            req_ack <= NUM_REQ'(1) << pick;
            cnt     <= CW'(ADD_LATENCY);
          end
        end
        WAIT: begin
          req_ack <= '0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_z   <= add_z;
            rsp_stb <= NUM_REQ'(1) << g;
          end
        end
        RESP: begin
          if (rsp_ack[g]) begin
            rsp_stb <= '0;
            last    <= g;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter: randomized lanes against a
// transaction-level round-robin model, plus directed scenarios.
module tb_fp_adder_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance with combinational adder
  logic [N-1:0]    req_stb, req_ack, rsp_stb, rsp_ack;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     rsp_z, add_a, add_b, add_z;
  logic            busy;
  logic [31:0]     la [N];
  logic [31:0]     lb [N];

  // Instance with 3-stage adder
  logic [N-1:0]    req_stb3, req_ack3, rsp_stb3, rsp_ack3;
  logic [32*N-1:0] req_a3, req_b3;
  logic [31:0]     rsp_z3, add_a3, add_b3, add_z3, p1, p2;
  logic            busy3;

  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    return r2s(sp2r(a) + sp2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom_range(1));
    e = 8'($urandom_range(134, 120));
    m = 23'($urandom);
    return {s, e, m};
  endfunction

  // Round-robin rule: first requesting lane after the last served one.
  function automatic int pick_rr(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = la[i];
      req_b[32*i +: 32] = lb[i];
    end
  end

  assign add_z = fadd(add_a, add_b);

  always @(posedge clk) begin
    p1     <= fadd(add_a3, add_b3);
    p2     <= p1;
    add_z3 <= p2;
  end

  fp_adder_arbiter #(.NUM_REQ(N), .ADD_LATENCY(0)) u0 (
    .clk(clk), .reset(reset),
    .req_stb(req_stb), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_z(rsp_z), .rsp_stb(rsp_stb),
    .rsp_ack(rsp_ack), .add_a(add_a), .add_b(add_b),
    .add_z(add_z), .busy(busy)
  );

  fp_adder_arbiter #(.NUM_REQ(N), .ADD_LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .req_stb(req_stb3), .req_a(req_a3), .req_b(req_b3),
    .req_ack(req_ack3), .rsp_z(rsp_z3), .rsp_stb(rsp_stb3),
    .rsp_ack(rsp_ack3), .add_a(add_a3), .add_b(add_b3),
    .add_z(add_z3), .busy(busy3)
  );

  // Transaction-level model state
  int          m_last;
  int          pend;
  logic [31:0] exp_z;
  int          ack_wait;
  int          waitg [N];
  int          gq [$];
  logic [N-1:0] persist;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_stb = '0;
    rsp_ack = '0;
    req_stb3 = '0;
    rsp_ack3 = '0;
    m_last = N - 1;
    pend = 0;
    exp_z = '0;
    ack_wait = 0;
    persist = '0;
    gq.delete();
    for (int i = 0; i < N; i++) waitg[i] = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Lane agents + scoreboard, evaluated at each falling edge.
  task automatic run(input int ncyc, input int ack_dly, input int p_new);
    for (int c = 0; c < ncyc; c++) begin
      if (req_ack != '0) begin
        int w;
        w = pick_rr(req_stb, m_last);
        n_chk++;
        if (req_ack !== onehot(w)) begin
          n_fail++;
          $display("FAIL grant: req_ack=%b expected %b", req_ack, onehot(w));
        end
        if (w >= 0) begin
          n_chk++;
          if (waitg[w] > N - 1) begin
            n_fail++;
            $display("FAIL fairness: lane %0d waited %0d grants, limit %0d",
                     w, waitg[w], N - 1);
          end
          for (int i = 0; i < N; i++)
            if (req_stb[i] && i != w) waitg[i]++;
          waitg[w] = 0;
          gq.push_back(w);
          pend = w;
          exp_z = fadd(la[w], lb[w]);
          ack_wait = (ack_dly > 0) ? $urandom_range(ack_dly) : 0;
          if (persist[w]) begin
            la[w] = rnd_fp();
            lb[w] = rnd_fp();
          end else begin
            req_stb[w] = 1'b0;
          end
        end
      end
      if (rsp_stb != '0) begin
        if (rsp_ack != '0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_release: rsp_stb=%b still high, expected 0", rsp_stb);
          rsp_ack = '0;
        end else if (ack_wait > 0) begin
          ack_wait--;
        end else begin
          n_chk++;
          if (rsp_stb !== onehot(pend) || rsp_z !== exp_z) begin
            n_fail++;
            $display("FAIL response: rsp_stb=%b rsp_z=%h expected %b %h",
                     rsp_stb, rsp_z, onehot(pend), exp_z);
          end
          rsp_ack = onehot(pend);
          m_last = pend;
        end
      end else begin
        rsp_ack = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (!req_stb[i] && $urandom_range(99) < p_new) begin
          req_stb[i] = 1'b1;
          la[i] = rnd_fp();
          lb[i] = rnd_fp();
          waitg[i] = 0;
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({req_ack, rsp_stb, busy} !== '0 || rsp_z !== '0) begin
      n_fail++;
      $display("FAIL reset_out: ack=%b stb=%b busy=%b z=%h expected all 0",
               req_ack, rsp_stb, busy, rsp_z);
    end
    n_chk++;
    if ({add_a, add_b} !== '0 || {req_ack3, rsp_stb3, busy3} !== '0) begin
      n_fail++;
      $display("FAIL reset_add: a=%h b=%h u3=%b expected 0",
               add_a, add_b, {req_ack3, rsp_stb3, busy3});
    end
    req_stb = '1;
    step();
    n_chk++;
    if (req_ack !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ack=%b busy=%b expected 0 0", req_ack, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    la[0] = 32'h3F800000;
    lb[0] = 32'h40000000;
    req_stb = 4'b0001;
    step();
    n_chk++;
    if (req_ack !== 4'b0001 || busy !== 1'b1 || rsp_stb !== '0) begin
      n_fail++;
      $display("FAIL single_grant: ack=%b busy=%b stb=%b expected 0001 1 0000",
               req_ack, busy, rsp_stb);
    end
    n_chk++;
    if (add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin
      n_fail++;
      $display("FAIL single_ops: a=%h b=%h expected 3f800000 40000000",
               add_a, add_b);
    end
    req_stb = '0;
    step();
    n_chk++;
    if (req_ack !== '0 || rsp_stb !== 4'b0001 || rsp_z !== 32'h40400000) begin
      n_fail++;
      $display("FAIL single_rsp: ack=%b stb=%b z=%h expected 0000 0001 40400000",
               req_ack, rsp_stb, rsp_z);
    end
    rsp_ack = 4'b0001;
    step();
    rsp_ack = '0;
    n_chk++;
    if (rsp_stb !== '0 || busy !== 1'b0 || rsp_z !== 32'h40400000) begin
      n_fail++;
      $display("FAIL single_done: stb=%b busy=%b z=%h expected 0000 0 40400000",
               rsp_stb, busy, rsp_z);
    end
  endtask

  task automatic test_all_lanes();
    do_reset();
    for (int i = 0; i < N; i++) begin
      la[i] = rnd_fp();
      lb[i] = rnd_fp();
    end
    req_stb = '1;
    run(40, 0, 0);
    n_chk++;
    if (gq.size() != 4 || gq[0] != 0 || gq[1] != 1 || gq[2] != 2 || gq[3] != 3) begin
      n_fail++;
      $display("FAIL all_order: %0d grants %p expected 0,1,2,3", gq.size(), gq);
    end
  endtask

  task automatic test_latency();
    do_reset();
    req_a3 = '0;
    req_b3 = '0;
    req_a3[64 +: 32] = 32'h3FC00000;
    req_b3[64 +: 32] = 32'h40200000;
    req_stb3 = 4'b0100;
    step();
    n_chk++;
    if (req_ack3 !== 4'b0100 || add_a3 !== 32'h3FC00000 || add_b3 !== 32'h40200000) begin
      n_fail++;
      $display("FAIL lat_grant: ack=%b a=%h b=%h expected 0100 3fc00000 40200000",
               req_ack3, add_a3, add_b3);
    end
    req_stb3 = '0;
    for (int k = 2; k <= 4; k++) begin
      step();
      n_chk++;
      if (rsp_stb3 !== '0 || req_ack3 !== '0 ||
          add_a3 !== 32'h3FC00000 || add_b3 !== 32'h40200000) begin
        n_fail++;
        $display("FAIL lat_wait%0d: stb=%b ack=%b a=%h b=%h expected idle, stable ops",
                 k, rsp_stb3, req_ack3, add_a3, add_b3);
      end
    end
    step();
    n_chk++;
    if (rsp_stb3 !== 4'b0100 || rsp_z3 !== 32'h40800000) begin
      n_fail++;
      $display("FAIL lat_rsp: stb=%b z=%h expected 0100 40800000", rsp_stb3, rsp_z3);
    end
    rsp_ack3 = 4'b0100;
    step();
    rsp_ack3 = '0;
    n_chk++;
    if (rsp_stb3 !== '0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_done: stb=%b busy=%b expected 0000 0", rsp_stb3, busy3);
    end
  endtask

  task automatic test_hold();
    logic [31:0] z;
    do_reset();
    la[1] = rnd_fp();
    lb[1] = rnd_fp();
    z = fadd(la[1], lb[1]);
    req_stb = 4'b0010;
    step();
    n_chk++;
    if (req_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_grant: ack=%b expected 0010", req_ack);
    end
    req_stb = '0;
    step();
    la[0] = rnd_fp();
    lb[0] = rnd_fp();
    req_stb = 4'b0001;
    rsp_ack = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (rsp_stb !== 4'b0010 || rsp_z !== z || req_ack !== '0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_c%0d: stb=%b z=%h ack=%b busy=%b expected 0010 %h 0000 1",
                 k, rsp_stb, rsp_z, req_ack, busy, z);
      end
      step();
    end
    rsp_ack = 4'b0010;
    step();
    rsp_ack = '0;
    n_chk++;
    if (rsp_stb !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_done: stb=%b busy=%b expected 0000 0", rsp_stb, busy);
    end
    step();
    n_chk++;
    if (req_ack !== 4'b0001 || add_a !== la[0]) begin
      n_fail++;
      $display("FAIL hold_next: ack=%b a=%h expected 0001 %h", req_ack, add_a, la[0]);
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    la[1] = rnd_fp();
    lb[1] = rnd_fp();
    req_stb = 4'b0010;
    step();
    req_stb = '0;
    step();
    rsp_ack = 4'b0010;
    step();
    rsp_ack = '0;
    la[3] = rnd_fp();
    lb[3] = rnd_fp();
    req_stb = 4'b1000;
    step();
    req_stb = '0;
    n_chk++;
    if (req_ack !== 4'b1000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_grant: ack=%b busy=%b expected 1000 1", req_ack, busy);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({req_ack, rsp_stb, busy} !== '0 || {rsp_z, add_a, add_b} !== '0) begin
      n_fail++;
      $display("FAIL rw_async: ack=%b stb=%b busy=%b z=%h a=%h b=%h expected all 0",
               req_ack, rsp_stb, busy, rsp_z, add_a, add_b);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (rsp_stb !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rw_discard%0d: stb=%b busy=%b expected 0000 0",
                 k, rsp_stb, busy);
      end
    end
    la[0] = rnd_fp();
    la[2] = rnd_fp();
    req_stb = 4'b0101;
    step();
    n_chk++;
    if (req_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL rw_prio: ack=%b expected 0001", req_ack);
    end
    req_stb = '0;
  endtask

  task automatic test_starvation();
    do_reset();
    persist[1] = 1'b1;
    la[1] = rnd_fp();
    lb[1] = rnd_fp();
    req_stb = 4'b0010;
    run(2, 0, 0);
    la[2] = rnd_fp();
    lb[2] = rnd_fp();
    req_stb[2] = 1'b1;
    waitg[2] = 0;
    run(30, 0, 0);
    n_chk++;
    if (gq.size() < 3 || gq[0] != 1 || gq[1] != 2 || gq[2] != 1) begin
      n_fail++;
      $display("FAIL starve_order: %p expected 1,2,1,...", gq);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) begin
      la[i] = rnd_fp();
      lb[i] = rnd_fp();
    end
    run(600, 3, 30);
    n_chk++;
    if (gq.size() < 40) begin
      n_fail++;
      $display("FAIL random_progress: %0d grants, expected at least 40", gq.size());
    end
  endtask

  initial begin
    req_stb = '0;
    rsp_ack = '0;
    req_stb3 = '0;
    rsp_ack3 = '0;
    req_a3 = '0;
    req_b3 = '0;
    persist = '0;
    for (int i = 0; i < N; i++) begin
      la[i] = '0;
      lb[i] = '0;
      waitg[i] = 0;
    end
    test_reset();
    test_single();
    test_all_lanes();
    test_latency();
    test_hold();
    test_reset_wait();
    test_starvation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
